// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: shares one single-ported, byte-banked memory_group between the
// instruction-fetch requester (f_*) and the load/store requester (d_*).
// One access is selected per cycle. The winner's payload is forwarded
// combinationally to the memory. The one-cycle-delayed read data is routed
// back to the requester that owned the access.
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to add the fetch
// starvation guard. A fetch refused STARVE_LIMIT consecutive cycles then
// wins over a concurrent data request. Without the macro, data always has
// priority over fetch.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   f_req, f_addr                  fetch request and byte address
//   f_gnt, f_rvalid, f_rdata       fetch accept, response valid, read data
//   d_req, d_addr                  load/store request and byte address
//   d_write_mask, d_write_data     byte write mask (0 = read) and store data
//   d_gnt, d_rvalid, d_rdata       load/store accept, response valid, read data
//   mem_addr, mem_write_mask,      to memory_group
//   mem_write_data
//   mem_read_data                  from memory_group, registered (1-cycle)
//
// Handshake: a requester raises *_req with a stable payload. It keeps both
// unchanged until it sees *_gnt. An access is accepted in the cycle where
// *_req && *_gnt. Exactly one *_rvalid pulse follows on the next cycle, in
// grant order. f_gnt and d_gnt are never high together, and both are low
// while rst is high.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DATA_DEPTH   = 4096,
  parameter int STARVE_LIMIT = 4,
  localparam int ADDR_W      = 2 + $clog2(DATA_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_write_mask,
  input  logic [31:0]       d_write_data,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_write_mask,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_check
    $error("mem_port_arbiter: STARVE_LIMIT must be within 1..255");
  end

  logic              starve_fire;
  logic [ADDR_W-1:0] last_addr;
  logic              resp_valid;
  logic              resp_owner;  // 0 = fetch, 1 = data

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  // Counts consecutive cycles in which fetch asked and was refused.
  logic [7:0] starve_cnt;

  assign starve_fire = (starve_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (!f_req || f_gnt) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != 8'hFF) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign starve_fire = 1'b0;
`endif

  // Data wins a collision unless fetch has waited long enough. Reset gates
  // both grants, so no write can reach the memory while rst is high.
  assign d_gnt = !rst && d_req && !(f_req && starve_fire);
  assign f_gnt = !rst && f_req && !d_gnt;

  // Winner mux. This is the only logic between *_req and mem_addr.
  // When idle, the address is held so the banks see no needless toggling.
  always_comb begin
    mem_addr       = last_addr;
    mem_write_mask = 4'b0000;
    mem_write_data = 32'd0;
    if (rst) begin
      mem_addr = '0;
    end else if (d_gnt) begin
      mem_addr       = d_addr;
      mem_write_mask = d_write_mask;
      mem_write_data = d_write_data;
    end else if (f_gnt) begin
      mem_addr = f_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr  <= '0;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
    end else begin
      last_addr  <= mem_addr;
      resp_valid <= f_gnt || d_gnt;
      resp_owner <= d_gnt;
    end
  end

  // The response is gated by rst. A reset in the cycle after acceptance
  // therefore drops the pending response as well.
  assign f_rvalid = !rst && resp_valid && !resp_owner;
  assign d_rvalid = !rst && resp_valid &&  resp_owner;

  assign f_rdata = mem_read_data;
  assign d_rdata = mem_read_data;

endmodule
